// File: rtl/ps2_pkg.sv
// Shared PS/2 types and command constants for the host transmitter and keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchroniser for a raw PS/2 line with a falling-edge pulse.
module ps2_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic [2:0] s;

    // Reset to the idle-high bus level so release of reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s <= 3'b111;
        end else begin
            s <= {s[1:0], raw};
        end
    end

    assign level = s[1];
    assign fall  = s[2] & ~s[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit shifting on
// device clock falls, ACK check and a per-edge watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       tx_active,
    output logic       done,
    output logic       err
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e    state_q, state_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [3:0]    n_q, n_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          nack_q, nack_d;
    logic          data_low_q, data_low_d;

    logic clk_s, clk_fall, data_s, unused_data_fall;
    logic watched, timeout;

    ps2_sync_edge u_sync_clk (
        .clk    (clk),
        .resetn (resetn),
        .raw    (ps2_clk),
        .level  (clk_s),
        .fall   (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk    (clk),
        .resetn (resetn),
        .raw    (ps2_data),
        .level  (data_s),
        .fall   (unused_data_fall)
    );

    assign watched = (state_q == REQ) || (state_q == SEND) ||
                     (state_q == ACK) || (state_q == WAIT_IDLE);
    assign timeout = watched && (wd_q == WW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            inh_q      <= '0;
            wd_q       <= '0;
            n_q        <= '0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            nack_q     <= 1'b0;
            data_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inh_q      <= inh_d;
            wd_q       <= wd_d;
            n_q        <= n_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            nack_q     <= nack_d;
            data_low_q <= data_low_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        inh_d      = inh_q;
        wd_d       = wd_q;
        n_d        = n_q;
        sh_d       = sh_q;
        par_d      = par_q;
        nack_d     = nack_q;
        data_low_d = data_low_q;
        if (timeout) begin
            data_low_d = 1'b0;
            state_d    = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    data_low_d = 1'b0;
                    if (tx_valid) begin
                        sh_d    = tx_data;
                        par_d   = odd_parity(tx_data);
                        inh_d   = '0;
                        state_d = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                        data_low_d = 1'b1;
                        wd_d       = '0;
                        n_d        = '0;
                        state_d    = REQ;
                    end else begin
                        inh_d = inh_q + IW'(1);
                    end
                end
                REQ, SEND: begin
                    if (clk_fall) begin
                        wd_d = '0;
                        n_d  = n_q + 4'd1;
                        if (n_q < 4'd8) begin
                            data_low_d = ~sh_q[0];
                            sh_d       = sh_q >> 1;
                        end else if (n_q == 4'd8) begin
                            data_low_d = ~par_q;
                        end else begin
                            data_low_d = 1'b0;
                        end
                        state_d = (n_q == 4'd9) ? ACK : SEND;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        nack_d  = data_s;
                        wd_d    = '0;
                        state_d = WAIT_IDLE;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        state_d = IDLE;
                    end else if (clk_fall) begin
                        wd_d = '0;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_ready           = (state_q == IDLE);
        tx_active          = (state_q != IDLE);
        ps2_clk_drive_low  = (state_q == INHIBIT);
        ps2_data_drive_low = data_low_q;
        done               = 1'b0;
        err                = 1'b0;
        if (timeout) begin
            err = 1'b1;
        end else if ((state_q == WAIT_IDLE) && clk_s && data_s) begin
            done = ~nack_q;
            err  = nack_q;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on the open-drain pair.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 8;
    localparam int unsigned TMO  = 400;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_active, done, err;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       ps2_clk, ps2_data;
    logic       dev_clk = 1'b1;
    logic       dev_data_low = 1'b0;

    assign ps2_clk  = dev_clk & ~ps2_clk_drive_low;
    assign ps2_data = ~(dev_data_low | ps2_data_drive_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .ps2_clk            (ps2_clk),
        .ps2_data           (ps2_data),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low),
        .tx_active          (tx_active),
        .done               (done),
        .err                (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Keyboard model: bits[0]=start, [8:1]=data, [9]=parity, [10]=stop, sampled at rising edges.
    task automatic dev_frame(input int nfalls, input bit nack, output logic [10:0] bits,
                             output bit ok);
        int t;
        bits = '0;
        ok   = 1'b0;
        t    = 0;
        while (!(tx_active && !ps2_clk_drive_low && ps2_data_drive_low) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) return;
        ok = 1'b1;
        repeat (5) @(negedge clk);
        bits[0] = ps2_data;
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk = 1'b0;
            if (i == nfalls && nfalls < 10) begin
                repeat (10) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            bits[i] = ps2_data;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = !nack;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk      = 1'b1;
        dev_data_low = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit nack, output logic [10:0] bits,
                             output bit ok);
        send(d);
        dev_frame(10, nack, bits, ok);
    endtask

    initial begin
        logic [10:0] bits, bits2;
        bit          ok, ok2;
        int          n, bad, d0, e0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_tx_active", tx_active, 0);
        check("rst_clk_low", ps2_clk_drive_low, 0);
        check("rst_data_low", ps2_data_drive_low, 0);
        check("rst_done_err", {done, err}, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 0xED with inhibit timing and ACK
        send(PS2_CMD_SET_LED);
        n   = 0;
        bad = 0;
        while (ps2_clk_drive_low && n < 100) begin
            if (ps2_data_drive_low) bad++;
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        check("inhibit_data_free", bad, 0);
        check("req_start_low", ps2_data_drive_low, 1);
        check("req_active", tx_active, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        dev_frame(10, 1'b0, bits, ok);
        check("ed_req_seen", ok, 1);
        check("ed_frame", bits, 11'h7DA);
        check("ed_done", done_cnt - d0, 1);
        check("ed_no_err", err_cnt - e0, 0);
        check("ed_ready", tx_ready, 1);

        // 2: parity 0 and parity 1 bytes
        d0 = done_cnt;
        run_frame(8'h01, 1'b0, bits, ok);
        check("x01_frame", bits, 11'h402);
        run_frame(PS2_CMD_RESET, 1'b0, bits, ok);
        check("xff_frame", bits, 11'h7FE);
        check("x01_xff_done", done_cnt - d0, 2);

        // 3: NACK
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(PS2_CMD_ENABLE, 1'b1, bits, ok);
        check("nack_err", err_cnt - e0, 1);
        check("nack_no_done", done_cnt - d0, 0);
        check("nack_released", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("nack_ready", tx_ready, 1);

        // 4: silent device -> watchdog
        e0 = err_cnt;
        send(PS2_CMD_RESET);
        n = 0;
        while (ps2_clk_drive_low && n < 100) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (!err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, TMO);
        @(negedge clk);
        check("timeout_released", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("timeout_idle", {tx_ready, tx_active}, 2'b10);
        check("timeout_err_once", err_cnt - e0, 1);

        // 5: reset during SEND after fall 4
        send(PS2_CMD_ENABLE);
        dev_frame(4, 1'b0, bits, ok);
        check("mid_active", tx_active, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_released", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("mid_rst_ready", tx_ready, 1);
        dev_clk = 1'b1;
        resetn  = 1'b1;
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        run_frame(PS2_CMD_ENABLE, 1'b0, bits, ok);
        check("f4_frame", bits, 11'h5E8);
        check("f4_done", done_cnt - d0, 1);

        // 6: tx_valid held across a busy frame
        d0 = done_cnt;
        tx_valid = 1'b1;
        tx_data  = PS2_CMD_SET_LED;
        @(negedge clk);
        tx_data = 8'h12;
        check("busy_not_ready", tx_ready, 0);
        dev_frame(10, 1'b0, bits, ok);
        tx_valid = 1'b0;
        dev_frame(10, 1'b0, bits2, ok2);
        check("first_byte", {ok, bits[8:1]}, {1'b1, PS2_CMD_SET_LED});
        check("second_byte", {ok2, bits2[8:1]}, 9'h112);
        check("two_done", done_cnt - d0, 2);
        repeat (50) @(negedge clk);
        check("no_third_frame", tx_active, 0);
        check("never_done_and_err", both_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
